// File: rtl/clock_reset_gen_if.sv
// clock_reset_gen_if: divisor write port and generated clock/reset outputs.
// Revision 1.0
`default_nettype none

interface clock_reset_gen_if #(
   parameter int DIV_W = 16
);
   logic [DIV_W-1:0] div;
   logic             div_we;
   logic             clk;
   logic             tick;
   logic             resetn;
   logic             div_pending;

   modport master (output div, div_we, input clk, tick, resetn, div_pending);
   modport slave  (input div, div_we, output clk, tick, resetn, div_pending);
endinterface

`default_nettype wire

// File: rtl/clock_reset_gen.sv
// clock_reset_gen: run-time programmable glitch-free clock divider with tick strobe
// and stretched, synchronously released active-low reset. Revision 1.0
`default_nettype none

module clock_reset_gen #(
   parameter int DIV_W    = 16,
   parameter int DIV_INIT = 10,
   parameter int RST_HOLD = 4
) (
   input  wire                CLK,
   input  wire                RESET,
   clock_reset_gen_if.slave   bus
);
   localparam int               HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DIV_INIT);

   typedef enum logic [1:0] {SYNC = 2'd0, HOLD = 2'd1, RUN = 2'd2} state_t;

   state_t             state, state_nx;
   logic [1:0]         sync_ff;
   logic [DIV_W-1:0]   cnt;
   logic [DIV_W-1:0]   div_act;
   logic [DIV_W-1:0]   div_shadow;
   logic               pending;
   logic               clk_div;
   logic               tick_q;
   logic               resetn_q;
   logic [HOLD_W-1:0]  hold_cnt, hold_nx;
   logic               release_rst;
   logic               running;
   logic               wrap;
   logic               fall_wrap;

   assign running   = sync_ff[1];
   assign wrap      = (cnt == div_act);
   assign fall_wrap = running & wrap & clk_div;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= SYNC;
         sync_ff  <= 2'b00;
         hold_cnt <= '0;
         resetn_q <= 1'b0;
      end else begin
         state    <= state_nx;
         sync_ff  <= {sync_ff[0], 1'b1};
         hold_cnt <= hold_nx;
         if (release_rst)
            resetn_q <= 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      hold_nx     = hold_cnt;
      release_rst = 1'b0;
      case (state)
         SYNC: if (running) state_nx = HOLD;
         HOLD: begin
            if (fall_wrap) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nx    = RUN;
                  release_rst = 1'b1;
               end else begin
                  hold_nx = hold_cnt + HOLD_W'(1);
               end
            end
         end
         RUN:     state_nx = RUN;
         default: state_nx = SYNC;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt     <= '0;
         clk_div <= 1'b0;
         tick_q  <= 1'b0;
      end else if (!running) begin
         cnt     <= '0;
         clk_div <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= wrap & ~clk_div;
         if (wrap) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

   // A write coinciding with a falling wrap still loads the old shadow; the new
   // value stays pending for the following period.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         div_act    <= DIV_RST;
         div_shadow <= DIV_RST;
         pending    <= 1'b0;
      end else begin
         if (fall_wrap && pending)
            div_act <= div_shadow;
         if (running && bus.div_we) begin
            div_shadow <= bus.div;
            pending    <= 1'b1;
         end else if (fall_wrap && pending) begin
            pending <= 1'b0;
         end
      end
   end

   assign bus.clk         = clk_div;
   assign bus.tick        = tick_q;
   assign bus.resetn      = resetn_q;
   assign bus.div_pending = pending;

endmodule

`default_nettype wire

// File: doc/clock_reset_gen.md
# clock_reset_gen

- Parametrised successor to the fixed free-running divider.
- Generates the design clock `clk` from the board clock `CLK`, with a divisor that can be changed at run time, glitch-free, at period boundaries.
- Also generates a one-cycle `tick` strobe and a stretched, synchronously released active-low `resetn` for the design.
- Sits at the top level between the board pins and the core.

## Interface

Parameters:
- `DIV_W`, 16: width of the divisor value and the phase counter.
- `DIV_INIT`, 10: active divisor after reset. Each `clk` phase lasts `DIV_INIT`+1 `CLK` cycles.
- `RST_HOLD`, 4: number of `clk` falling edges, after reset synchronisation, before `resetn` is released. Must be ≥1.

Ports:
- `CLK` in 1: board clock; the only clock of the block. All flops are on posedge `CLK`.
- `RESET` in 1: board reset, asynchronous, active-high.
- `div` in `DIV_W`: new divisor value.
- `div_we` in 1: write strobe for `div`. Sampled on posedge `CLK`.
- `clk` out 1: divided clock for the design.
- `tick` out 1: high for exactly one `CLK` cycle, starting at each `clk` rising edge.
- `resetn` out 1: active-low reset for the design.
- `div_pending` out 1: a written divisor is waiting to be applied.

## Operation

- While `RESET`=1 (asynchronous): all outputs are 0. Both the active and shadow divisor are `DIV_INIT`. Phase counter `cnt`=0, hold counter = 0, sync pair = 00.
- Reset FSM:
  - SYNC: a 2-flop synchroniser shifts in 1 after `RESET` falls. While sync[1]=0, the divider is frozen (`cnt`=0, `clk`=0).
  - HOLD: the divider runs and the hold counter counts `clk` falling edges. On the `RST_HOLD`-th falling edge, `resetn`←1 and the FSM moves to RUN.
  - RUN: terminal state. It is left only by `RESET`.
- Divider (running whenever sync[1]=1):
  - wrap = (`cnt`==`div_act`).
  - On wrap: `cnt`←0 and `clk`←~`clk`. Otherwise `cnt`←`cnt`+1.
  - `tick`←wrap & ~`clk`, i.e. `tick` is high in the `CLK` cycle in which `clk` is first 1.
- Divisor update:
  - `div_we`=1 with sync[1]=1: shadow←`div`, `div_pending`←1.
  - At a falling wrap (wrap & `clk`=1) with `div_pending`=1: `div_act`←shadow, `div_pending`←0.
  - Simultaneous `div_we` and falling wrap: `div_act` takes the old shadow value. The shadow takes the new `div` value. `div_pending` stays 1, so the new value is applied at the next falling wrap.
  - Back-to-back writes before application: the last write wins.
  - `div_we` is ignored while sync[1]=0.
- `div`=0 gives `clk` = `CLK`/2. The maximum value gives phases of 2^`DIV_W` cycles. `cnt` never exceeds `div_act`, so there is no overflow.
- `resetn` changes only on the edge where `clk` falls. It is therefore stable for a full `clk` high-to-low half period before the design's next posedge `clk`.

## Timing

- E0 is the first posedge `CLK` with `RESET`=0.
  - E0: sync=01.
  - E1: sync=11.
  - E(2+`div_act`): first `clk` rise, with `tick` high in the cycle that follows.
  - Rise and fall edges alternate every `div_act`+1 edges.
  - `resetn` rises at E(1+2·`RST_HOLD`·(`div_act`+1)).
- `clk` duty cycle is exactly 50%. Its period is 2·(`div_act`+1) `CLK` cycles.
- The divisor applies from the low phase that starts at the falling wrap. Every `clk` period is built entirely from one divisor, so no runt phase occurs.
- Latency from `div_we` to application is between 1 and 2·(old+1) `CLK` cycles.
- `RESET` mid-operation:
  - Immediate asynchronous clear: `clk`=0, `resetn`=0, `tick`=0, `div_pending`=0, divisors=`DIV_INIT`.
  - A truncated `clk` high phase is acceptable.
  - Release then follows the full SYNC/HOLD sequence again.

## Test plan

1. Reset release, `DIV_INIT`=0, `RST_HOLD`=1 → `clk` rises at E2 and falls at E3, `resetn` rises at E3, and `tick` is high only in the cycle after E2.
2. Defaults (`DIV_INIT`=10, `RST_HOLD`=4) → `clk` period 22 with 11 high/11 low, `resetn` rises at E89, and `tick` is high for exactly one cycle per period.
3. In RUN with div_act=10, write `div`=3 mid high phase → `div_pending`=1. The current period completes at 22, then periods are 8, and `div_pending`=0 at the falling wrap.
4. `div_we` with `div`=5 on the exact falling-wrap edge while shadow=3 is pending → the next period is 8, the period after is 12, and `div_pending` clears one period later.
5. `RESET` pulse of 1 `CLK` cycle mid high phase → `clk`, `resetn` and `tick` drop to 0 asynchronously and `div_act` returns to `DIV_INIT`. The full reset sequence then repeats with timing identical to scenario 2.
6. `div_we` while `RESET`=1 or during SYNC → ignored: `div_pending` stays 0 and the period remains `DIV_INIT`-based.
